// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between bus masters and the 8-way round-robin arbiter.
// master drives en/req; slave (arbiter) returns the registered grant signals.
interface rr_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  preempt
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output preempt
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold timeout; grant registered one cycle after request.
// Owner keeps the grant until release, en low or timeout; handover happens with no dead cycle.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter8_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit               TO_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_TO  = TO_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t           state;
  logic [7:0]       gnt_q;
  logic [2:0]       idx_q;
  logic             vld_q;
  logic             pre_q;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [7:0] cand;
  logic       win_found;
  logic [2:0] win_idx;
  logic       owner_req;
  logic       timeout;

  // Current owner is never a candidate: on release its bit is already low,
  // and on timeout it must be skipped. ptr is always owner+1 while granted.
  assign cand      = bus.req & ~gnt_q;
  assign owner_req = bus.req[idx_q];
  assign timeout   = TO_EN && (hold_cnt >= CNT_TO);

  always_comb begin : search
    logic [2:0] probe;
    probe     = '0;
    win_found = 1'b0;
    win_idx   = '0;
    // Scan farthest offset first so the nearest set bit to ptr wins.
    for (int i = 7; i >= 0; i--) begin
      probe = ptr + 3'(i);
      if (cand[probe]) begin
        win_found = 1'b1;
        win_idx   = probe;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt_q    <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
      pre_q    <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      pre_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && win_found) begin
            state    <= GRANT;
            gnt_q    <= 8'b1 << win_idx;
            idx_q    <= win_idx;
            vld_q    <= 1'b1;
            ptr      <= win_idx + 3'd1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (!bus.en || (!owner_req && !win_found)) begin
            state    <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            vld_q    <= 1'b0;
            hold_cnt <= '0;
          end else if (!owner_req || (timeout && win_found)) begin
            // Release takes precedence over timeout, so preempt only when owner still wants it.
            gnt_q    <= 8'b1 << win_idx;
            idx_q    <= win_idx;
            ptr      <= win_idx + 3'd1;
            hold_cnt <= '0;
            pre_q    <= owner_req;
          end else if (hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = vld_q;
  assign bus.preempt   = pre_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic against a cycle reference model.
// Model tracks owner/pointer/cycles-held as integers and applies the arbitration rules directly.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst;
  rr_arbiter8_if bus();

  rr_arbiter8 #(.MAX_HOLD(MH), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: owner -1 means nobody holds the grant; held counts grant cycles so far.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_pre   = 1'b0;

  function automatic int pick(input logic [7:0] r, input int from, input int excl);
    for (int i = 0; i < 8; i++) begin
      int j;
      j = (from + i) % 8;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic r, input logic e, input logic [7:0] q);
    int w;
    logic [7:0] others;
    if (r) begin
      m_owner = -1; m_ptr = 0; m_held = 0; m_pre = 1'b0;
      return;
    end
    m_pre = 1'b0;
    if (m_owner < 0) begin
      if (e) begin
        w = pick(q, m_ptr, -1);
        if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % 8; m_held = 1; end
      end
    end else if (!e) begin
      m_owner = -1; m_held = 0;
    end else if (!q[m_owner]) begin
      w = pick(q, m_owner + 1, -1);
      m_owner = w;
      if (w >= 0) begin m_ptr = (w + 1) % 8; m_held = 1; end
      else m_held = 0;
    end else begin
      others = q;
      others[m_owner] = 1'b0;
      if (MH != 0 && m_held >= MH && others != 8'h00) begin
        w = pick(q, m_owner + 1, m_owner);
        m_owner = w; m_ptr = (w + 1) % 8; m_held = 1; m_pre = 1'b1;
      end else begin
        m_held++;
      end
    end
  endfunction

  task automatic check(input string tag);
    logic [7:0] eg;
    logic [2:0] ei;
    logic       ev;
    eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    ev = (m_owner >= 0);
    vectors++;
    assert (bus.gnt === eg) else begin
      miscompares++; $error("FAIL %s gnt observed=%h expected=%h", tag, bus.gnt, eg);
    end
    vectors++;
    assert (bus.gnt_idx === ei) else begin
      miscompares++; $error("FAIL %s gnt_idx observed=%0d expected=%0d", tag, bus.gnt_idx, ei);
    end
    vectors++;
    assert (bus.gnt_valid === ev) else begin
      miscompares++; $error("FAIL %s gnt_valid observed=%b expected=%b", tag, bus.gnt_valid, ev);
    end
    vectors++;
    assert (bus.preempt === m_pre) else begin
      miscompares++; $error("FAIL %s preempt observed=%b expected=%b", tag, bus.preempt, m_pre);
    end
    vectors++;
    assert ($onehot0(bus.gnt) === 1'b1) else begin
      miscompares++; $error("FAIL %s onehot observed=%h expected=at most one bit", tag, bus.gnt);
    end
  endtask

  // Literal expectation taken straight from the scenario description.
  task automatic lit(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [7:0] q, input string tag);
    rst = r; bus.en = e; bus.req = q;
    @(posedge clk);
    model_step(r, e, q);
    #1;
    check(tag);
  endtask

  initial begin
    logic [7:0] rq;
    logic       re;
    logic       rr;

    rst = 1'b1; bus.en = 1'b0; bus.req = 8'h00;

    // Reset and idle
    cyc(1, 1, 8'hFF, "reset");
    lit("reset_gnt", bus.gnt, 8'h00);
    cyc(1, 0, 8'h00, "reset2");
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'h00, "idle");
    lit("idle_vld", {7'd0, bus.gnt_valid}, 8'h00);

    // Same-edge handover 2 -> 5, then release to idle
    cyc(0, 1, 8'h24, "pair_first");
    lit("pair_first_gnt", bus.gnt, 8'h04);
    cyc(0, 1, 8'h24, "pair_hold");
    cyc(0, 1, 8'h20, "pair_handover");
    lit("pair_handover_gnt", bus.gnt, 8'h20);
    cyc(0, 1, 8'h20, "pair_hold5");
    cyc(0, 1, 8'h00, "pair_release");
    lit("pair_release_gnt", bus.gnt, 8'h00);

    // Full rotation with wrap
    cyc(1, 1, 8'h00, "rot_reset");
    cyc(0, 1, 8'hFF, "rot_start");
    lit("rot_start_idx", {5'd0, bus.gnt_idx}, 8'h00);
    for (int k = 0; k < 8; k++) begin
      rq = 8'hFF;
      rq[k] = 1'b0;
      cyc(0, 1, rq, "rotate");
      lit("rotate_idx", {5'd0, bus.gnt_idx}, 8'((k + 1) % 8));
    end

    // Hold timeout and preempt pulse
    cyc(1, 1, 8'h00, "to_reset");
    cyc(0, 1, 8'h08, "to_grant3");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 8'h48, "to_hold");
      lit("to_hold_gnt", bus.gnt, 8'h08);
    end
    cyc(0, 1, 8'h48, "to_fire");
    lit("to_fire_gnt", bus.gnt, 8'h40);
    lit("to_fire_pre", {7'd0, bus.preempt}, 8'h01);
    cyc(0, 1, 8'h48, "to_after");
    lit("to_after_pre", {7'd0, bus.preempt}, 8'h00);
    cyc(0, 1, 8'h08, "to_regrant3");
    lit("to_regrant3_gnt", bus.gnt, 8'h08);
    // Alone past the limit, then a late competitor triggers an immediate handover
    for (int i = 0; i < 6; i++) cyc(0, 1, 8'h08, "to_alone");
    cyc(0, 1, 8'h09, "to_late");
    lit("to_late_gnt", bus.gnt, 8'h01);
    lit("to_late_pre", {7'd0, bus.preempt}, 8'h01);

    // Enable drop keeps ptr
    cyc(1, 1, 8'h00, "en_reset");
    cyc(0, 1, 8'h02, "en_grant1");
    cyc(0, 0, 8'h13, "en_low1");
    lit("en_low_gnt", bus.gnt, 8'h00);
    cyc(0, 0, 8'h13, "en_low2");
    cyc(0, 1, 8'h13, "en_back");
    lit("en_back_gnt", bus.gnt, 8'h10);

    // Reset during a grant returns ptr to 0
    cyc(1, 1, 8'h00, "rm_reset");
    cyc(0, 1, 8'h80, "rm_grant7");
    lit("rm_grant7_gnt", bus.gnt, 8'h80);
    cyc(1, 1, 8'h80, "rm_rst");
    lit("rm_rst_gnt", bus.gnt, 8'h00);
    cyc(0, 1, 8'h81, "rm_after");
    lit("rm_after_gnt", bus.gnt, 8'h01);

    // Random traffic: requests persist for a while so holds, releases and timeouts all occur
    rq = 8'h00;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
      re = ($urandom_range(0, 15) != 0);
      rr = ($urandom_range(0, 63) == 0);
      cyc(rr, re, rq, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- 8-requester round-robin arbiter for the shared 3-to-8 one-hot select resource.
- Picks one requester, drives its 3-bit index and the matching one-hot grant, holds the grant until release or hold timeout, then rotates priority.
- Sits between bus masters and any 8-way one-hot-selected resource; gnt is the decoded form of gnt_idx.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles for one owner while others wait; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; low drops the grant and stops new grants.
- req  input  8  request per requester; held high for the whole use, dropped to release.
- gnt  output  8  registered one-hot grant; all zero when no owner.
- gnt_idx  output  3  registered index of the owner; 0 when no owner.
- gnt_valid  output  1  high when gnt is non-zero.
- preempt  output  1  one-cycle pulse in the cycle after a timeout-forced handover.

Behaviour:
- Reset: state IDLE, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0, hold_cnt=0, priority pointer ptr=0 (requester 0 searched first). rst wins over all other inputs.
- Invariant: gnt == one-hot decode of gnt_idx when gnt_valid=1, else gnt == 0. Never more than one bit set.
- Winner search: first set bit of the candidate mask scanning ptr, ptr+1, ... ptr+7, modulo 8.
- IDLE:
  - If en=1 and req != 0: register winner w. Next cycle gnt_valid=1, gnt_idx=w, state GRANT, hold_cnt=0.
  - Latency is one cycle from request to grant.
  - Otherwise stay in IDLE.
- GRANT (owner o):
  - hold_cnt increments each cycle and saturates at MAX_HOLD.
  - Release (req[o]=0): on the same edge, re-arbitrate with ptr=o+1 over the current req. If a winner exists, hand over with no dead cycle; otherwise go to IDLE with gnt=0.
  - Timeout (MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, req[o]=1, and another req bit set): on the same edge, re-arbitrate with ptr=o+1 and bit o masked out. The new owner gets the grant next cycle, and preempt=1 for exactly that cycle.
  - Timeout with no other requester: owner keeps the grant, hold_cnt holds at MAX_HOLD, and timeout re-fires as soon as another request appears.
  - Release and timeout in the same cycle: treat as release, with no preempt pulse.
- ptr update: on each new grant to w, ptr becomes w+1 mod 8 (wraps 7 to 0). ptr is unchanged in IDLE and when en drops.
- en=0 in GRANT: next cycle gnt=0, gnt_valid=0, state IDLE, hold_cnt=0, no preempt. Re-arbitration resumes one cycle after en returns high.
- A request that drops before it is granted is simply not granted; no latching of pulses.
- Reset mid-grant: the grant is removed on the next edge and ptr returns to 0.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> gnt=0, gnt_idx=0, gnt_valid=0 throughout.
- From reset, req=8'h24 (bits 2, 5) -> one cycle later gnt=8'h04, gnt_idx=2. Drop bit 2 -> same-edge handover: next cycle gnt=8'h20, gnt_idx=5. Drop bit 5 -> next cycle gnt=0.
- All req=8'hFF, each owner releasing for one cycle after each grant -> grant order 0,1,2,...,7,0 (wrap); gnt is always one-hot.
- MAX_HOLD=4, req[3] held, req[6] raised -> owner 3 has 4 grant cycles. Then gnt=8'h40, preempt=1 for exactly 1 cycle. When 6 releases with req[3] still high -> 3 re-granted.
- Owner 1 with en pulled low for 2 cycles -> gnt=0 the cycle after en falls. After en rises, owner is the first requester at or after index 2 (ptr unchanged), one cycle later.
- rst asserted while gnt=8'h80 -> next cycle all outputs 0. After rst, req=8'h81 -> gnt=8'h01 (ptr back to 0).
